// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor D = a - b - Bin, BITS_PER_CYCLE bits per clock through one borrow chain.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned BPC   = BITS_PER_CYCLE;
    localparam int unsigned STEPS = (BPC == 0) ? 1 : WIDTH / BPC;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (WIDTH < 2 || BPC == 0 || (WIDTH % BPC) != 0) begin : g_bad_params
        $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    logic [BPC-1:0]   chunk_c;
    logic             chain_bout_c;
    logic [WIDTH-1:0] res_next_c;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_bin_c;
`endif

    // Shared borrow chain over the low BPC bits of the operand shift registers.
    always_comb begin
        chunk_c      = '0;
        chain_bout_c = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        msb_bin_c    = borrow_q;
`endif
        for (int i = 0; i < int'(BPC); i++) begin
`ifdef SERIAL_SUB_OVF_EN
            msb_bin_c    = chain_bout_c;
`endif
            chunk_c[i]   = a_q[i] ^ b_q[i] ^ chain_bout_c;
            chain_bout_c = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chain_bout_c);
        end
    end

    // New difference chunk enters from the MSB side.
    assign res_next_c = (res_q >> BPC) | (WIDTH'(chunk_c) << (WIDTH - BPC));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                a_d      = a_q >> BPC;
                b_d      = b_q >> BPC;
                res_d    = res_next_c;
                borrow_d = chain_bout_c;
                cnt_d    = cnt_q + CNT_W'(1);
                busy_d   = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    d_d     = res_next_c;
                    bout_d  = chain_bout_c;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = msb_bin_c ^ chain_bout_c;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=8 (1 and 4 bits/cycle) and WIDTH=4.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       start8, start8w, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8, busy8w, done8w, bout8w;
    logic [7:0] d8, d8w;
    logic       start4, bin4;
    logic [3:0] a4, b4;
    logic       busy4a, done4a, bout4a, busy4b, done4b, bout4b;
    logic [3:0] d4a, d4b;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf8w, ovf4a, ovf4b;
`endif

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );
    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u8w (
        .clk(clk), .rst(rst), .start(start8w), .a(a8), .b(b8), .Bin(bin8),
        .busy(busy8w), .done(done8w), .D(d8w), .Bout(bout8w)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8w)
`endif
    );
    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(1)) u4a (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .Bin(bin4),
        .busy(busy4a), .done(done4a), .D(d4a), .Bout(bout4a)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4a)
`endif
    );
    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(4)) u4b (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .Bin(bin4),
        .busy(busy4b), .done(done4b), .D(d4b), .Bout(bout4b)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4b)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation on both 8-bit instances; called at posedge+1.
    task automatic op8(input vec_t v, input string tag);
        int lm, lw;
        logic [7:0] dm, dw;
        logic bm, bw;
`ifdef SERIAL_SUB_OVF_EN
        logic om, ow;
`endif
        lm = -1; lw = -1; dm = 'x; dw = 'x; bm = 1'bx; bw = 1'bx;
        a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1; start8w = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start8w = 1'b0;
        check({tag, "_busy_main"}, 32'(busy8), 32'd1);
        check({tag, "_busy_wide"}, 32'(busy8w), 32'd1);
        for (int c = 1; c <= 20 && (lm < 0 || lw < 0); c++) begin
            @(posedge clk); #1;
            if (done8 && lm < 0) begin
                lm = c; dm = d8; bm = bout8;
`ifdef SERIAL_SUB_OVF_EN
                om = ovf8;
`endif
            end
            if (done8w && lw < 0) begin
                lw = c; dw = d8w; bw = bout8w;
`ifdef SERIAL_SUB_OVF_EN
                ow = ovf8w;
`endif
            end
        end
        check({tag, "_lat_main"}, 32'(lm), 32'd8);
        check({tag, "_lat_wide"}, 32'(lw), 32'd2);
        check({tag, "_D_main"}, 32'(dm), 32'(v.d));
        check({tag, "_Bout_main"}, 32'(bm), 32'(v.bout));
        check({tag, "_D_wide"}, 32'(dw), 32'(v.d));
        check({tag, "_Bout_wide"}, 32'(bw), 32'(v.bout));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf_main"}, 32'(om), 32'(v.ovf));
        check({tag, "_ovf_wide"}, 32'(ow), 32'(v.ovf));
`endif
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
        check({tag, "_D_hold"}, 32'(d8), 32'(v.d));
    endtask

    // One operation on both 4-bit instances against an arithmetic golden model.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [4:0] full;
        int r, la, lb;
        logic [3:0] da, db;
        logic ba, bb;
`ifdef SERIAL_SUB_OVF_EN
        logic oa, ob, oexp;
`endif
        full = {1'b0, a} - {1'b0, b} - 5'(bin);
        r = int'($signed(a)) - int'($signed(b)) - int'(bin);
`ifdef SERIAL_SUB_OVF_EN
        oexp = (r > 7) || (r < -8);
`endif
        la = -1; lb = -1; da = 'x; db = 'x; ba = 1'bx; bb = 1'bx;
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int c = 1; c <= 10 && (la < 0 || lb < 0); c++) begin
            @(posedge clk); #1;
            if (done4a && la < 0) begin
                la = c; da = d4a; ba = bout4a;
`ifdef SERIAL_SUB_OVF_EN
                oa = ovf4a;
`endif
            end
            if (done4b && lb < 0) begin
                lb = c; db = d4b; bb = bout4b;
`ifdef SERIAL_SUB_OVF_EN
                ob = ovf4b;
`endif
            end
        end
        check($sformatf("w4_%h_%h_%0d_lat1", a, b, bin), 32'(la), 32'd4);
        check($sformatf("w4_%h_%h_%0d_lat4", a, b, bin), 32'(lb), 32'd1);
        check($sformatf("w4_%h_%h_%0d_D1", a, b, bin), 32'(da), 32'(full[3:0]));
        check($sformatf("w4_%h_%h_%0d_D4", a, b, bin), 32'(db), 32'(full[3:0]));
        check($sformatf("w4_%h_%h_%0d_B1", a, b, bin), 32'(ba), 32'(full[4]));
        check($sformatf("w4_%h_%h_%0d_B4", a, b, bin), 32'(bb), 32'(full[4]));
`ifdef SERIAL_SUB_OVF_EN
        check($sformatf("w4_%h_%h_%0d_O1", a, b, bin), 32'(oa), 32'(oexp));
        check($sformatf("w4_%h_%h_%0d_O4", a, b, bin), 32'(ob), 32'(oexp));
`endif
    endtask

    initial begin
        int lm;
        logic seen;
        vec_t v;

        tbl[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 8'h00, b: 8'h01, bin: 1'b1, d: 8'hFE, bout: 1'b1, ovf: 1'b0};
        tbl[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bout: 1'b0, ovf: 1'b0};
        tbl[4] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
        tbl[5] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bout: 1'b0, ovf: 1'b1};
        tbl[6] = '{a: 8'h03, b: 8'h01, bin: 1'b0, d: 8'h02, bout: 1'b0, ovf: 1'b0};
        tbl[7] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1};

        rst = 1'b1;
        start8 = 1'b0; start8w = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_D", 32'(d8), 32'd0);
        check("rst_Bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) op8(tbl[i], $sformatf("v%0d", i));

        // Start during RUN is ignored; start at DONE chains without a bubble.
        a8 = 8'h20; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("hs_busy", 32'(busy8), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("hs_busy_ignored", 32'(busy8), 32'd1);
        check("hs_D_hold_run", 32'(d8), 32'(tbl[7].d));
        lm = -1;
        for (int c = 4; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done8) begin lm = c; break; end
        end
        check("hs_lat", 32'(lm), 32'd8);
        check("hs_D", 32'(d8), 32'h1B);
        check("hs_Bout", 32'(bout8), 32'd0);
        a8 = 8'h44; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("b2b_busy", 32'(busy8), 32'd1);
        check("b2b_done_low", 32'(done8), 32'd0);
        check("b2b_D_hold", 32'(d8), 32'h1B);
        lm = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done8) begin lm = c; break; end
        end
        check("b2b_lat", 32'(lm), 32'd8);
        check("b2b_D", 32'(d8), 32'h33);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an operation.
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        check("mid_rst_D", 32'(d8), 32'd0);
        check("mid_rst_Bout", 32'(bout8), 32'd0);
        check("mid_rst_D_wide", 32'(d8w), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        v = '{a: 8'h03, b: 8'h01, bin: 1'b0, d: 8'h02, bout: 1'b0, ovf: 1'b0};
        op8(v, "post_rst");

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int bi = 0; bi < 2; bi++)
                    op4(4'(x), 4'(y), 1'(bi));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
